clock_time_ctrl: RTL and testbench

//  Sequencer for the digital-clock datapath: drives three cascaded two-digit BCD counters
//  (sec/min/hour) from a 1 Hz tick. Provides a button-driven time-set FSM (mode/inc).

---
 rtl/clock_ctrl_pkg.sv | 17 +
 rtl/clock_time_ctrl_bcd_mod_counter.sv | 39 +++
 rtl/clock_time_ctrl.sv | 142 ++++++++++++++
 tb/tb_clock_time_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_ctrl_pkg.sv
// Shared constants for the digital-clock sequencer: FSM state codes and BCD helpers.
package clock_ctrl_pkg;

   localparam logic [2:0] RUN       = 3'd0;
   localparam logic [2:0] SET_HOUR  = 3'd1;
   localparam logic [2:0] SET_MIN   = 3'd2;
   localparam logic [2:0] SET_AHOUR = 3'd3;
   localparam logic [2:0] SET_AMIN  = 3'd4;

   localparam logic [7:0] BCD_59   = 8'h59;
   localparam logic [7:0] BCD_ZERO = 8'h00;

   function automatic logic [7:0] to_bcd(input int n);
      return {4'(n / 10), 4'(n % 10)};
   endfunction

endpackage

// File: rtl/clock_time_ctrl_bcd_mod_counter.sv
// Two-digit BCD counter that wraps at MOD-1 back to 00; carry flags the wrapping increment.
module bcd_mod_counter
   import clock_ctrl_pkg::*;
#(
   parameter int MOD = 60
) (
   input  logic       CP,
   input  logic       CR,
   input  logic       clr,
   input  logic       inc,
   output logic [7:0] q,
   output logic       carry
);

   localparam logic [7:0] TOP = to_bcd(MOD - 1);

   logic at_top;

   assign at_top = (q == TOP);
   assign carry  = inc & at_top;

   // Clear takes priority over increment so a counter can be zeroed on the same edge it would count.
   always_ff @(posedge CP or negedge CR) begin
      if (!CR) begin
         q <= BCD_ZERO;
      end else if (clr) begin
         q <= BCD_ZERO;
      end else if (inc) begin
         if (at_top) begin
            q <= BCD_ZERO;
         end else if (q[3:0] == 4'd9) begin
            q <= {q[7:4] + 4'd1, 4'd0};
         end else begin
            q <= {q[7:4], q[3:0] + 4'd1};
         end
      end
   end

endmodule

// File: rtl/clock_time_ctrl.sv
// Digital-clock sequencer: cascaded BCD time counters plus button-driven set FSM.
// Optional alarm set/compare is enabled by defining CLOCK_ALARM_EN.
module clock_time_ctrl
   import clock_ctrl_pkg::*;
#(
   parameter int HOUR_MOD = 24
) (
   input  logic       CP,
   input  logic       CR,
   input  logic       tick,
   input  logic       btn_mode,
   input  logic       btn_inc,
   output logic [7:0] hour,
   output logic [7:0] min,
   output logic [7:0] sec,
   output logic [2:0] mode_state,
   output logic       blink,
   output logic       alarm_hit
);

   logic [2:0] state;
   logic [2:0] state_next;
   logic       mode_q;
   logic       inc_q;
   logic       mode_edge;
   logic       inc_edge;
   logic       run;
   logic       run_tick;
   logic       set_inc;
   logic       sec_carry;
   logic       min_carry;
   logic       hour_carry_unused;

   assign mode_edge  = btn_mode & ~mode_q;
   assign inc_edge   = btn_inc & ~inc_q;
   assign run        = (state == RUN);
   assign run_tick   = run & tick;
   assign set_inc    = inc_edge & ~mode_edge;
   assign mode_state = state;

   // Seconds are zeroed as the FSM leaves RUN for SET_HOUR, even if a tick arrives on that edge.
   bcd_mod_counter #(.MOD(60)) u_sec (
      .CP    (CP),
      .CR    (CR),
      .clr   (run & mode_edge),
      .inc   (run_tick),
      .q     (sec),
      .carry (sec_carry)
   );

   bcd_mod_counter #(.MOD(60)) u_min (
      .CP    (CP),
      .CR    (CR),
      .clr   (1'b0),
      .inc   ((run & sec_carry) | ((state == SET_MIN) & set_inc)),
      .q     (min),
      .carry (min_carry)
   );

   // Minute wrap only ripples into hours while running; setting minutes never touches the hour.
   bcd_mod_counter #(.MOD(HOUR_MOD)) u_hour (
      .CP    (CP),
      .CR    (CR),
      .clr   (1'b0),
      .inc   ((run & min_carry) | ((state == SET_HOUR) & set_inc)),
      .q     (hour),
      .carry (hour_carry_unused)
   );

   always_comb begin
      state_next = state;
      if (mode_edge) begin
         case (state)
            RUN:       state_next = SET_HOUR;
            SET_HOUR:  state_next = SET_MIN;
`ifdef CLOCK_ALARM_EN
            SET_MIN:   state_next = SET_AHOUR;
            SET_AHOUR: state_next = SET_AMIN;
            SET_AMIN:  state_next = RUN;
`else
            SET_MIN:   state_next = RUN;
`endif
            default:   state_next = RUN;
         endcase
      end
   end

   // Blink is held low while running and restarts low whenever the field being set changes.
   always_ff @(posedge CP or negedge CR) begin
      if (!CR) begin
         state  <= RUN;
         mode_q <= 1'b0;
         inc_q  <= 1'b0;
         blink  <= 1'b0;
      end else begin
         state  <= state_next;
         mode_q <= btn_mode;
         inc_q  <= btn_inc;
         if (mode_edge || run) begin
            blink <= 1'b0;
         end else if (tick) begin
            blink <= ~blink;
         end
      end
   end

`ifdef CLOCK_ALARM_EN
   logic [7:0] ahour;
   logic [7:0] amin;
   logic       ahour_carry_unused;
   logic       amin_carry_unused;

   bcd_mod_counter #(.MOD(HOUR_MOD)) u_ahour (
      .CP    (CP),
      .CR    (CR),
      .clr   (1'b0),
      .inc   ((state == SET_AHOUR) & set_inc),
      .q     (ahour),
      .carry (ahour_carry_unused)
   );

   bcd_mod_counter #(.MOD(60)) u_amin (
      .CP    (CP),
      .CR    (CR),
      .clr   (1'b0),
      .inc   ((state == SET_AMIN) & set_inc),
      .q     (amin),
      .carry (amin_carry_unused)
   );

   always_ff @(posedge CP or negedge CR) begin
      if (!CR) begin
         alarm_hit <= 1'b0;
      end else begin
         alarm_hit <= run && (hour == ahour) && (min == amin);
      end
   end
`else
   assign alarm_hit = 1'b0;
`endif

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Self-checking bench for clock_time_ctrl: HOUR_MOD 24 and 12 instances against a seconds-count model.
module tb_clock_time_ctrl;

   logic       CP = 1'b0;
   logic       CR = 1'b0;
   logic       tick = 1'b0;
   logic       btn_mode = 1'b0;
   logic       btn_inc = 1'b0;

   logic [7:0] hour_a, min_a, sec_a, hour_b, min_b, sec_b;
   logic [2:0] state_a, state_b;
   logic       blink_a, blink_b, alarm_a, alarm_b;

`ifdef CLOCK_ALARM_EN
   localparam bit ALARM_ON = 1'b1;
   localparam int NPOS = 5;
`else
   localparam bit ALARM_ON = 1'b0;
   localparam int NPOS = 3;
`endif

   clock_time_ctrl #(.HOUR_MOD(24)) dut_a (
      .CP(CP), .CR(CR), .tick(tick), .btn_mode(btn_mode), .btn_inc(btn_inc),
      .hour(hour_a), .min(min_a), .sec(sec_a), .mode_state(state_a),
      .blink(blink_a), .alarm_hit(alarm_a)
   );

   clock_time_ctrl #(.HOUR_MOD(12)) dut_b (
      .CP(CP), .CR(CR), .tick(tick), .btn_mode(btn_mode), .btn_inc(btn_inc),
      .hour(hour_b), .min(min_b), .sec(sec_b), .mode_state(state_b),
      .blink(blink_b), .alarm_hit(alarm_b)
   );

   always #5 CP = ~CP;

   int total_checks = 0;
   int passed_checks = 0;

   // Reference model: time kept as plain integers, position in the mode cycle as an index.
   int hmod [2] = '{24, 12};
   int mh [2], mm [2], ms [2], mah [2], mam [2];
   bit malarm [2];
   int mpos;
   bit mblink, pmode, pinc;

   function automatic logic [7:0] bcd8(input int n);
      logic [3:0] t, u;
      t = 4'(n / 10);
      u = 4'(n % 10);
      return {t, u};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         mh[i] = 0; mm[i] = 0; ms[i] = 0; mah[i] = 0; mam[i] = 0; malarm[i] = 1'b0;
      end
      mpos = 0; mblink = 1'b0; pmode = 1'b0; pinc = 1'b0;
   endtask

   task automatic model_step(input bit tk, input bit md, input bit ic);
      bit me, ie;
      int t;
      me = md & ~pmode;
      ie = ic & ~pinc;
      pmode = md;
      pinc = ic;
      for (int i = 0; i < 2; i++) begin
         bit hit;
         hit = ALARM_ON && (mpos == 0) && (mh[i] == mah[i]) && (mm[i] == mam[i]);
         if (mpos == 0 && tk) begin
            t = (mh[i] * 3600 + mm[i] * 60 + ms[i] + 1) % (hmod[i] * 3600);
            mh[i] = t / 3600;
            mm[i] = (t / 60) % 60;
            ms[i] = t % 60;
         end
         if (ie && !me) begin
            case (mpos)
               1: mh[i] = (mh[i] + 1) % hmod[i];
               2: mm[i] = (mm[i] + 1) % 60;
               3: mah[i] = (mah[i] + 1) % hmod[i];
               4: mam[i] = (mam[i] + 1) % 60;
               default: ;
            endcase
         end
         if (me && mpos == 0) ms[i] = 0;
         malarm[i] = hit;
      end
      if (me || mpos == 0) mblink = 1'b0;
      else if (tk) mblink = ~mblink;
      if (me) mpos = (mpos + 1) % NPOS;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_checks++;
      if (act !== exp) $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      else passed_checks++;
   endtask

   task automatic compare_all();
      chk("hour24", hour_a, bcd8(mh[0]));
      chk("min24", min_a, bcd8(mm[0]));
      chk("sec24", sec_a, bcd8(ms[0]));
      chk("state24", state_a, mpos);
      chk("blink24", blink_a, mblink);
      chk("alarm24", alarm_a, malarm[0]);
      chk("hour12", hour_b, bcd8(mh[1]));
      chk("min12", min_b, bcd8(mm[1]));
      chk("sec12", sec_b, bcd8(ms[1]));
      chk("state12", state_b, mpos);
      chk("blink12", blink_b, mblink);
      chk("alarm12", alarm_b, malarm[1]);
   endtask

   // Called at a falling edge; drives inputs, lets one rising edge pass, checks, returns at next falling edge.
   task automatic applyStimulus(input bit tk, input bit md, input bit ic);
      tick = tk; btn_mode = md; btn_inc = ic;
      @(posedge CP);
      model_step(tk, md, ic);
      #1;
      compare_all();
      @(negedge CP);
   endtask

   task automatic do_reset();
      @(negedge CP);
      CR = 1'b0; tick = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
      model_reset();
      #1;
      compare_all();
      @(negedge CP);
      CR = 1'b1;
   endtask

   task automatic press_mode();
      applyStimulus(0, 1, 0);
      applyStimulus(0, 0, 0);
   endtask

   task automatic press_inc(input int n);
      for (int k = 0; k < n; k++) begin
         applyStimulus(0, 0, 1);
         applyStimulus(0, 0, 0);
      end
   endtask

   task automatic goto_run();
      for (int k = 0; k < 6 && mpos != 0; k++) press_mode();
   endtask

   typedef struct {
      bit tk;
      bit md;
      bit ic;
      logic [7:0] h;
      logic [7:0] m;
      logic [7:0] s;
      logic [2:0] st;
   } vec_t;

   vec_t tbl [12];

   initial begin
      tbl[0]  = '{1, 0, 0, 8'h00, 8'h00, 8'h01, 3'd0};
      tbl[1]  = '{1, 0, 0, 8'h00, 8'h00, 8'h02, 3'd0};
      tbl[2]  = '{1, 1, 0, 8'h00, 8'h00, 8'h00, 3'd1};
      tbl[3]  = '{0, 0, 1, 8'h01, 8'h00, 8'h00, 3'd1};
      tbl[4]  = '{0, 0, 0, 8'h01, 8'h00, 8'h00, 3'd1};
      tbl[5]  = '{0, 0, 1, 8'h02, 8'h00, 8'h00, 3'd1};
      tbl[6]  = '{0, 0, 1, 8'h02, 8'h00, 8'h00, 3'd1};
      tbl[7]  = '{1, 0, 0, 8'h02, 8'h00, 8'h00, 3'd1};
      tbl[8]  = '{0, 1, 1, 8'h02, 8'h00, 8'h00, 3'd2};
      tbl[9]  = '{0, 0, 0, 8'h02, 8'h00, 8'h00, 3'd2};
      tbl[10] = '{0, 0, 1, 8'h02, 8'h01, 8'h00, 3'd2};
      tbl[11] = '{1, 0, 0, 8'h02, 8'h01, 8'h00, 3'd2};

      model_reset();
      #12;
      do_reset();

      // Directed table
      for (int i = 0; i < 12; i++) begin
         applyStimulus(tbl[i].tk, tbl[i].md, tbl[i].ic);
         chk($sformatf("tbl%0d_hour", i), hour_a, tbl[i].h);
         chk($sformatf("tbl%0d_min", i), min_a, tbl[i].m);
         chk($sformatf("tbl%0d_sec", i), sec_a, tbl[i].s);
         chk($sformatf("tbl%0d_state", i), state_a, tbl[i].st);
      end

      // 60 ticks from reset
      do_reset();
      for (int i = 0; i < 60; i++) begin
         applyStimulus(1, 0, 0);
         if (i == 58) chk("sec_at_59", sec_a, 8'h59);
      end
      chk("sec_wrap", sec_a, 8'h00);
      chk("min_after_60", min_a, 8'h01);

      // Preset 23:59:59 (11:59:59 for the 12-hour instance) and roll over
      do_reset();
      press_mode();
      press_inc(23);
      press_mode();
      press_inc(59);
      goto_run();
      for (int i = 0; i < 59; i++) applyStimulus(1, 0, 0);
      chk("pre_hour24", hour_a, 8'h23);
      chk("pre_hour12", hour_b, 8'h11);
      chk("pre_min", min_a, 8'h59);
      chk("pre_sec", sec_a, 8'h59);
      applyStimulus(1, 0, 0);
      chk("roll_time24", {hour_a, min_a, sec_a}, 24'h000000);
      chk("roll_time12", {hour_b, min_b, sec_b}, 24'h000000);

      // Set hour 05 then 61 minute increments
      do_reset();
      applyStimulus(1, 0, 0);
      press_mode();
      press_inc(5);
      chk("set_hour05", hour_a, 8'h05);
      chk("set_sec00", sec_a, 8'h00);
      press_mode();
      press_inc(61);
      chk("set_min01", min_a, 8'h01);
      chk("hour_kept05", hour_a, 8'h05);

      // Asynchronous reset in the middle of SET_MIN with blink high
      applyStimulus(1, 0, 0);
      chk("blink_before_reset", blink_a, 1'b1);
      @(negedge CP);
      #2 CR = 1'b0;
      model_reset();
      #1;
      chk("async_time", {hour_a, min_a, sec_a}, 24'h000000);
      chk("async_state", state_a, 3'd0);
      chk("async_blink", blink_a, 1'b0);
      compare_all();
      @(negedge CP);
      CR = 1'b1;

      // Alarm at 00:02 (stays low when the alarm feature is absent)
      do_reset();
      if (ALARM_ON) begin
         for (int k = 0; k < 4; k++) press_mode();
         press_inc(2);
         goto_run();
      end
      for (int i = 0; i < 185; i++) begin
         applyStimulus(1, 0, 0);
         if (i == 124) chk("alarm_at_02", alarm_a, ALARM_ON);
      end
      chk("alarm_at_03", alarm_a, 1'b0);

      // Randomized traffic
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         applyStimulus(($urandom % 3) == 0, ($urandom_range(0, 11) == 0), ($urandom % 3) == 0);
      end

      $display("[TB] %0d/%0d checks passed", passed_checks, total_checks);
      $finish;
   end

endmodule
